// File: rtl/cache_perf_monitor_if.sv
// cache_perf_monitor_if: control, event-strobe and read-port bundle for the
// cache performance monitor. The master side drives run control, strobes and
// the read select; the slave side (the monitor) returns read data and status.
interface cache_perf_monitor_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 32
);
   localparam int SEL_W = $clog2(3 * NUM_CH + 1);

   logic              start_i;
   logic              clr_i;
   logic [CNT_W-1:0]  cyc_limit_i;
   logic [NUM_CH-1:0] acc_i;
   logic [NUM_CH-1:0] hit_i;
   logic [NUM_CH-1:0] miss_i;
   logic              snap_i;
   logic [SEL_W-1:0]  rd_sel_i;
   logic [CNT_W-1:0]  rd_data_o;
   logic              busy_o;
   logic              done_o;
   logic [NUM_CH-1:0] err_o;

   modport master (
      output start_i, clr_i, cyc_limit_i, acc_i, hit_i, miss_i, snap_i, rd_sel_i,
      input  rd_data_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, clr_i, cyc_limit_i, acc_i, hit_i, miss_i, snap_i, rd_sel_i,
      output rd_data_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor: per-channel access/hit/miss counters plus a cycle
// counter over a bounded run window, sticky protocol-error flags and a
// registered read port. All counters saturate.
// Optional feature macro: PERF_SNAPSHOT_EN (atomic shadow bank behind snap_i).
module cache_perf_monitor #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   cache_perf_monitor_if.slave bus
);
   localparam int NUM_CNT = 3 * NUM_CH + 1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   state_e            state_q, state_d;
   logic              busy_q, done_q;
   logic [NUM_CH-1:0] err_q, err_d;
   cnt_t              cnt_q  [NUM_CNT];
   cnt_t              cnt_d  [NUM_CNT];
   cnt_t              rd_src [NUM_CNT];
   cnt_t              rd_data_q, rd_data_d;
   logic              run;
   logic              lim_hit;

   // Saturating increment: a full counter stays full instead of wrapping.
   function automatic cnt_t sat_inc(input cnt_t v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) return v + cnt_t'(1);
      return v;
   endfunction

   assign run = (state_q == RUN);

   // The run ends on the edge whose increment lands exactly on the limit, so a
   // limit lowered below the current count never stops the run early.
   assign lim_hit = (bus.cyc_limit_i != '0) &&
                    (cnt_q[0] != {CNT_W{1'b1}}) &&
                    ((cnt_q[0] + cnt_t'(1)) == bus.cyc_limit_i);

   // Next state: clear dominates, start is ignored while running.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_i) state_d = RUN;
         RUN:     if (lim_hit)     state_d = DONE;
         DONE:    if (bus.start_i) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (bus.clr_i) state_d = IDLE;
   end

   // Counter updates: every strobe counts on its own, only while running.
   always_comb begin
      cnt_d[0] = sat_inc(cnt_q[0], run);
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[1 + 3*c] = sat_inc(cnt_q[1 + 3*c], run & bus.acc_i[c]);
         cnt_d[2 + 3*c] = sat_inc(cnt_q[2 + 3*c], run & bus.hit_i[c]);
         cnt_d[3 + 3*c] = sat_inc(cnt_q[3 + 3*c], run & bus.miss_i[c]);
      end
      if (bus.clr_i) begin
         for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
      end
   end

   // Sticky protocol errors: hit together with miss, or hit/miss without access.
   always_comb begin
      err_d = err_q;
      if (state_q != IDLE) begin
         err_d = err_q | (bus.hit_i & bus.miss_i) |
                 ((bus.hit_i | bus.miss_i) & ~bus.acc_i);
      end
      if (bus.clr_i) err_d = '0;
   end

`ifdef PERF_SNAPSHOT_EN
   cnt_t shd_q [NUM_CNT];
   cnt_t shd_d [NUM_CNT];
   logic snap_vld_q, snap_vld_d;

   // Shadow bank captures the post-increment counter values in one edge.
   always_comb begin
      snap_vld_d = snap_vld_q;
      for (int i = 0; i < NUM_CNT; i++) shd_d[i] = shd_q[i];
      if (bus.snap_i) begin
         snap_vld_d = 1'b1;
         for (int i = 0; i < NUM_CNT; i++) shd_d[i] = cnt_d[i];
      end
      if (bus.clr_i) begin
         snap_vld_d = 1'b0;
         for (int i = 0; i < NUM_CNT; i++) shd_d[i] = '0;
      end
   end

   // Shadow bank registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_vld_q <= 1'b0;
         for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= '0;
      end else begin
         snap_vld_q <= snap_vld_d;
         for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= shd_d[i];
      end
   end

   // Once a snapshot exists, reads see it instead of the live counters.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) rd_src[i] = snap_vld_q ? shd_q[i] : cnt_q[i];
   end
`else
   logic unused_snap;
   assign unused_snap = bus.snap_i;

   // Reads always see the live counters.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) rd_src[i] = cnt_q[i];
   end
`endif

   // Read mux: unmapped selects return zero.
   always_comb begin
      rd_data_d = '0;
      if (int'(bus.rd_sel_i) < NUM_CNT) rd_data_d = rd_src[bus.rd_sel_i];
   end

   // Control state, status decodes and error flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         err_q   <= err_d;
      end
   end

   // Counter bank and read register (read sees pre-increment values).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
         rd_data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.rd_data_o = rd_data_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.err_o     = err_q;
endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb_cache_perf_monitor: drives a 32-bit and an 8-bit counter instance with the
// same stimulus and compares both against a behavioural model every cycle,
// plus directed scenarios with literal expected values.
module tb_cache_perf_monitor;
   localparam int NCH  = 3;
   localparam int NCNT = 3 * NCH + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, clr = 1'b0, snap = 1'b0;
   logic [31:0] lim = '0;
   logic [2:0]  acc = '0, hit = '0, miss = '0;
   logic [3:0]  sel = '0;
   bit          chk_en = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   cache_perf_monitor_if #(.NUM_CH(NCH), .CNT_W(32)) bus32 ();
   cache_perf_monitor_if #(.NUM_CH(NCH), .CNT_W(8))  bus8  ();

   cache_perf_monitor #(.NUM_CH(NCH), .CNT_W(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
   cache_perf_monitor #(.NUM_CH(NCH), .CNT_W(8))  dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

   assign bus32.start_i     = start;
   assign bus32.clr_i       = clr;
   assign bus32.cyc_limit_i = lim;
   assign bus32.acc_i       = acc;
   assign bus32.hit_i       = hit;
   assign bus32.miss_i      = miss;
   assign bus32.snap_i      = snap;
   assign bus32.rd_sel_i    = sel;
   assign bus8.start_i      = start;
   assign bus8.clr_i        = clr;
   assign bus8.cyc_limit_i  = lim[7:0];
   assign bus8.acc_i        = acc;
   assign bus8.hit_i        = hit;
   assign bus8.miss_i       = miss;
   assign bus8.snap_i       = snap;
   assign bus8.rd_sel_i     = sel;

   // ---------------- behavioural model (index 0: 32-bit, 1: 8-bit) ----------
   longint   m_cnt [2][NCNT];
   longint   m_shd [2][NCNT];
   bit       m_svld [2];
   int       m_st [2];      // 0 idle, 1 running, 2 finished
   bit [2:0] m_err [2];
   longint   m_rd [2];

   task automatic model_clear(input int k);
      for (int i = 0; i < NCNT; i++) begin
         m_cnt[k][i] = 0;
         m_shd[k][i] = 0;
      end
      m_svld[k] = 0;
      m_st[k]   = 0;
      m_err[k]  = '0;
   endtask

   task automatic model_step(input int k);
      longint mx, L;
      bit     reached;
      mx = (k == 0) ? 64'hFFFF_FFFF : 64'd255;
      L  = (k == 0) ? longint'(lim) : longint'(lim[7:0]);
      // read reflects the values held before this edge
      if (int'(sel) < NCNT) m_rd[k] = m_svld[k] ? m_shd[k][sel] : m_cnt[k][sel];
      else                  m_rd[k] = 0;
      if (clr) begin
         model_clear(k);
         return;
      end
      if (m_st[k] != 0) begin
         for (int c = 0; c < NCH; c++)
            if ((hit[c] && miss[c]) || ((hit[c] || miss[c]) && !acc[c])) m_err[k][c] = 1'b1;
      end
      reached = 0;
      if (m_st[k] == 1) begin
         if (m_cnt[k][0] < mx) begin
            m_cnt[k][0] = m_cnt[k][0] + 1;
            reached = (L != 0) && (m_cnt[k][0] == L);
         end
         for (int c = 0; c < NCH; c++) begin
            if (acc[c]  && m_cnt[k][1+3*c] < mx) m_cnt[k][1+3*c] = m_cnt[k][1+3*c] + 1;
            if (hit[c]  && m_cnt[k][2+3*c] < mx) m_cnt[k][2+3*c] = m_cnt[k][2+3*c] + 1;
            if (miss[c] && m_cnt[k][3+3*c] < mx) m_cnt[k][3+3*c] = m_cnt[k][3+3*c] + 1;
         end
      end
`ifdef PERF_SNAPSHOT_EN
      if (snap) begin
         m_svld[k] = 1;
         for (int i = 0; i < NCNT; i++) m_shd[k][i] = m_cnt[k][i];
      end
`endif
      if ((m_st[k] == 0 || m_st[k] == 2) && start) m_st[k] = 1;
      else if (m_st[k] == 1 && reached)           m_st[k] = 2;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_rd[k] = 0;
         end
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd32",   64'(bus32.rd_data_o), 64'(m_rd[0]));
         chk("busy32", 64'(bus32.busy_o),    64'(m_st[0] == 1));
         chk("done32", 64'(bus32.done_o),    64'(m_st[0] == 2));
         chk("err32",  64'(bus32.err_o),     64'(m_err[0]));
         chk("rd8",    64'(bus8.rd_data_o),  64'(m_rd[1]));
         chk("busy8",  64'(bus8.busy_o),     64'(m_st[1] == 1));
         chk("done8",  64'(bus8.done_o),     64'(m_st[1] == 2));
         chk("err8",   64'(bus8.err_o),      64'(m_err[1]));
      end
   end

   task automatic rd_lit(input string nm, input int idx, input longint e32, input longint e8);
      sel = 4'(idx);
      @(negedge clk);
      chk({nm, "_32"}, 64'(bus32.rd_data_o), 64'(e32));
      chk({nm, "_8"},  64'(bus8.rd_data_o),  64'(e8));
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      // reset state
      chk("rst_busy", 64'(bus32.busy_o),    64'd0);
      chk("rst_done", 64'(bus32.done_o),    64'd0);
      chk("rst_err",  64'(bus32.err_o),     64'd0);
      chk("rst_rd",   64'(bus32.rd_data_o), 64'd0);

      // 10-cycle run, acc+hit on channel 0 every cycle
      lim = 32'd10; acc = 3'b001; hit = 3'b001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("t1_done_early", 64'(bus32.done_o), 64'd0);
      @(negedge clk);
      chk("t1_done", 64'(bus32.done_o), 64'd1);
      chk("t1_busy", 64'(bus32.busy_o), 64'd0);
      acc = '0; hit = '0;
      rd_lit("t1_idx0", 0, 10, 10);
      rd_lit("t1_idx1", 1, 10, 10);
      rd_lit("t1_idx2", 2, 10, 10);
      rd_lit("t1_idx3", 3, 0, 0);
      chk("t1_err", 64'(bus32.err_o), 64'd0);

      // channel 1: 3 hits + 1 miss; channel 2: hit without access
      pulse_clr();
      lim = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 3'b010; hit = 3'b010;
      repeat (3) @(negedge clk);
      hit = '0; miss = 3'b010;
      @(negedge clk);
      acc = '0; miss = '0; hit = 3'b100;
      @(negedge clk);
      hit = '0;
      @(negedge clk);
      chk("t2_err", 64'(bus32.err_o), 64'd4);
      rd_lit("t2_idx4", 4, 4, 4);
      rd_lit("t2_idx5", 5, 3, 3);
      rd_lit("t2_idx6", 6, 1, 1);
      rd_lit("t2_idx8", 8, 1, 1);
      rd_lit("t2_idx12", 12, 0, 0);
      pulse_clr();
      chk("t2_err_clr", 64'(bus32.err_o), 64'd0);
      chk("t2_busy_clr", 64'(bus32.busy_o), 64'd0);

      // saturation: unbounded run, 300 accesses on channel 0
      lim = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 3'b001;
      repeat (300) @(negedge clk);
      acc = '0;
      @(negedge clk);
      chk("t3_busy", 64'(bus8.busy_o), 64'd1);
      rd_lit("t3_idx1", 1, 300, 255);
      chk("t3_busy_late", 64'(bus32.busy_o), 64'd1);

      // clear and start together while running
      clr = 1'b1; start = 1'b1;
      @(negedge clk);
      clr = 1'b0; start = 1'b0;
      chk("t4_busy", 64'(bus32.busy_o), 64'd0);
      chk("t4_done", 64'(bus32.done_o), 64'd0);
      rd_lit("t4_idx0", 0, 0, 0);
      rd_lit("t4_idx1", 1, 0, 0);

      // asynchronous reset mid-run, then restart from zero
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 3'b011; hit = 3'b110;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 64'(bus32.busy_o),    64'd0);
      chk("t5_rd",   64'(bus32.rd_data_o), 64'd0);
      chk("t5_err",  64'(bus32.err_o),     64'd0);
      acc = '0; hit = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 3'b001;
      repeat (5) @(negedge clk);
      acc = '0;
      rd_lit("t5_idx1", 1, 5, 5);

      // snapshot in cycle 5 of a 20-cycle run
      pulse_clr();
      lim = 32'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0; acc = 3'b001;
      repeat (4) @(negedge clk);
      snap = 1'b1;
      @(negedge clk);
      snap = 1'b0;
      repeat (20) @(negedge clk);
      acc = '0;
      chk("t6_done", 64'(bus32.done_o), 64'd1);
`ifdef PERF_SNAPSHOT_EN
      rd_lit("t6_idx1", 1, 5, 5);
`else
      rd_lit("t6_idx1", 1, 20, 20);
`endif

      // randomized traffic against the model
      pulse_clr();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 15) == 0);
         clr   = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 31) == 0)
            lim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
         acc  = 3'($urandom);
         hit  = acc & 3'($urandom);
         miss = acc & ~hit & 3'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            hit  = 3'($urandom);
            miss = 3'($urandom);
         end
         snap = ($urandom_range(0, 59) == 0);
         sel  = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      start = 1'b0; clr = 1'b0; snap = 1'b0; acc = '0; hit = '0; miss = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/cache_perf_monitor.md
# cache_perf_monitor

Parametrised cache performance monitor for the riscv_cache top level. It counts accesses, hits and misses for NUM_CH cache channels (default L1-I, L1-D, L2) over a bounded run window. It flags protocol violations on the event strobes and exposes all counters through a registered read port. It replaces ad-hoc bench-side counting with synthesizable counters, so the same figures are available on FPGA (via io_* muxing) and in simulation.

## Interface

Parameters:
- NUM_CH, 3, number of monitored cache channels (1..8).
- CNT_W, 32, width of every counter and of rd_data_o (8..64).
- SEL_W, $clog2(3*NUM_CH+1), width of rd_sel_i (derived, do not override).

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  pulse; begins a run window.
- clr_i  in  1  synchronous clear of all counters, error flags and state.
- cyc_limit_i  in  CNT_W  run length in cycles; 0 = unbounded.
- acc_i  in  NUM_CH  per-channel access strobe, one cycle per access.
- hit_i  in  NUM_CH  per-channel hit strobe.
- miss_i  in  NUM_CH  per-channel miss strobe.
- snap_i  in  1  snapshot request (used only with PERF_SNAPSHOT_EN).
- rd_sel_i  in  SEL_W  counter select.
- rd_data_o  out  CNT_W  selected counter, registered.
- busy_o  out  1  state == RUN.
- done_o  out  1  state == DONE.
- err_o  out  NUM_CH  sticky per-channel protocol-error flags.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN on start_i.
- RUN → DONE on the edge where the cycle counter reaches cyc_limit_i (when the limit is non-zero).
- DONE → RUN on start_i. The new run continues counting from the current values; it does not clear them.
- clr_i: from any state, go to IDLE and zero all counters, err_o and the snapshot. clr_i has priority over start_i in the same cycle.
- start_i while in RUN is ignored.
- Counters: cycle counter, plus acc, hit and miss per channel.
- All counters increment only in cycles where the state is RUN.
- All counters saturate at 2^CNT_W−1 and never wrap.
- Each strobe is counted independently, including illegal combinations.
- Protocol error for channel c is set in any state except IDLE when either condition holds:
  - hit_i[c] & miss_i[c]
  - (hit_i[c] | miss_i[c]) & ~acc_i[c]
  Once set, the flag holds until clr_i or reset.
- Read map:
  - index 0 = cycle counter.
  - 1+3c = acc[c].
  - 2+3c = hit[c].
  - 3+3c = miss[c].
  - Indices ≥ 3·NUM_CH+1 return 0.

## Timing

- Reset values: all counters 0, rd_data_o = 0, busy_o = 0, done_o = 0, err_o = 0, snapshot = 0.
- Reset mid-run aborts the run immediately, with no partial hold.
- start_i sampled at edge k: state is RUN after edge k. Strobes in the cycle after edge k are the first ones counted.
- With cyc_limit_i = L > 0, exactly L RUN cycles are counted:
  - the cycle counter equals L in DONE;
  - done_o rises on the edge that counts the L-th cycle.
- cyc_limit_i is sampled every RUN cycle. If it is lowered below the current count, the run continues until the counter saturates or clr_i is asserted; no early stop.
- A strobe in cycle N is visible in its counter after edge N.
- rd_data_o has 1-cycle latency: rd_sel_i sampled at edge N appears on rd_data_o after edge N. A read of a counter in the same cycle it increments returns the pre-increment value.
- busy_o and done_o are registered state decodes with no combinational path from inputs.

## Configuration

- PERF_SNAPSHOT_EN defined:
  - snap_i copies every counter into a shadow bank on the next edge, atomically.
  - Reads return shadow values from then on, until clr_i.
  - snap_i together with a strobe: the shadow captures the post-increment value.
- PERF_SNAPSHOT_EN undefined:
  - snap_i is ignored and no shadow registers exist.
  - Reads always return live counters.

## Test plan

- Reset, then start_i with cyc_limit_i = 10 and acc+hit on channel 0 every cycle → done_o after 10 RUN cycles; reads give idx0 = 10, idx1 = 10, idx2 = 10, idx3 = 0; err_o = 0.
- Channel 1 with acc on 4 cycles: 3 hits and 1 miss; channel 2 strobes hit_i without acc_i once → idx4 = 4, idx5 = 3, idx6 = 1; err_o = 3'b100 until clr_i, then 0.
- CNT_W = 8, cyc_limit_i = 0, acc on channel 0 for 300 cycles → idx1 = 255 (saturated); busy_o stays 1.
- clr_i and start_i in the same cycle during RUN → state IDLE, all reads 0, busy_o = 0.
- rst_ni asserted mid-run for 1 cycle → all outputs 0 immediately; a later start_i restarts from zero.
- With PERF_SNAPSHOT_EN: snap_i at cycle 5 of a 20-cycle run with a continuous acc on channel 0 → idx1 reads 5 after done_o. Without the macro, idx1 reads 20.
